// File: rtl/fifo_core.sv
// Single-clock first-word-fall-through FIFO with full / one-place-left /
// empty / one-datum occupancy flags decoded from a registered count.
module fifo_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  we_in,
    input  logic                  re_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full_out,
    output logic                  one_p_out,
    output logic                  empty_out,
    output logic                  one_d_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_P = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wa;
    logic             ra;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wa       = we_in & ~full_out;
        ra       = re_in & ~empty_out;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wa) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (ra) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wa, ra})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; an empty FIFO masks its contents.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    assign full_out  = (count_q == CNT_FULL);
    assign one_p_out = (count_q == CNT_ONE_P);
    assign empty_out = (count_q == '0);
    assign one_d_out = (count_q == CNT_ONE);
    assign data_out  = empty_out ? '0 : mem[rd_ptr_q];

endmodule

// File: doc/fifo_core.md
# fifo_core

Synchronous single-clock FIFO that sits behind the bench-side DUT pin bundle (`data_to_DUT`, `we_out`, `re_out`, `data_from_DUT`, `full_in`, `one_p_in`, `empty_in`, `one_d_in`) as the design under test. It accepts writes and reads on the same clock and reports four occupancy flags: full, one place left, empty, one datum held. The read port is first-word-fall-through.

## Interface
- `DATA_WIDTH`, default 32: data word width in bits.
- `DEPTH`, default 8: number of entries. Any integer ≥ 2; need not be a power of two.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `clk`.
- `data_in`  in  DATA_WIDTH: write data, connected to `data_to_DUT`.
- `we_in`  in  1: write request, connected to `we_out`.
- `re_in`  in  1: read/pop request, connected to `re_out`.
- `data_out`  out  DATA_WIDTH: head-of-queue data, connected to `data_from_DUT`.
- `full_out`  out  1: occupancy == DEPTH.
- `one_p_out`  out  1: occupancy == DEPTH-1 (one place left).
- `empty_out`  out  1: occupancy == 0.
- `one_d_out`  out  1: occupancy == 1 (one datum held).

## Operation
- State:
  - storage array `DEPTH` × `DATA_WIDTH`, not reset
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each 0..DEPTH-1
  - occupancy counter `count`, 0..DEPTH, width `$clog2(DEPTH+1)`
- Write accept: `wa = we_in & ~full_out`. On accept, `mem[wr_ptr] <= data_in` and `wr_ptr` advances.
- Read accept: `ra = re_in & ~empty_out`. On accept, `rd_ptr` advances.
- Pointer advance: increments by 1; at DEPTH-1 it wraps to 0. Explicit compare; no reliance on power-of-two overflow.
- Count update:
  - `wa & ~ra`: +1
  - `ra & ~wa`: -1
  - both or neither: unchanged
- Rejected requests:
  - Write while full: ignored. Storage, pointers and count are unchanged and no error is raised.
  - Read while empty: ignored, with the same guarantees.
- Simultaneous we/re:
  - While empty: only the write is accepted; count goes 0→1.
  - While full: only the read is accepted; count goes DEPTH→DEPTH-1.
  - Otherwise: both are accepted, count is unchanged, both pointers advance.
- Flags: decoded combinationally from the registered `count` only, with no dependence on the current-cycle `we_in`/`re_in`.
  - With DEPTH=2, `one_p_out` and `one_d_out` are both 1 at count 1.
- `data_out`:
  - Equals `mem[rd_ptr]` when `empty_out`=0.
  - Forced to 0 when `empty_out`=1.
- Reset (async assert):
  - Pointers 0, count 0.
  - Outputs: `empty_out`=1, `full_out`=0, `one_p_out`=0, `one_d_out`=0, `data_out`=0.
  - Storage contents are not cleared, but are unobservable because the FIFO reads as empty.
  - Reset asserted mid-operation discards all queued data at once.

## Timing
- Write-to-read latency: 1 cycle. Data written at edge k appears on `data_out`, with `empty_out`=0, right after edge k, and may be popped at edge k+1.
- Pop: `data_out` shows the next entry right after the edge that accepts the read.
- Flag update: flags reflect accepts at edge k right after edge k. Requests are sampled at the edge; no combinational path from request inputs to outputs.
- No input-to-output combinational path. `data_out` and the flags depend only on registered state and storage.
- Back-to-back: one write and one read per cycle are sustainable indefinitely when 0 < count < DEPTH.

## Test plan
DEPTH=4, DATA_WIDTH=32 for all scenarios.
- Reset: drive `rst_n`=0 mid-cycle → outputs immediately show `empty_out`=1, others 0, `data_out`=0. Release, then read → nothing popped and all flags unchanged.
- Fill/drain: write 0xA0..0xA3 on 4 consecutive cycles. Flags after each edge:
  - `one_d_out`
  - none
  - `one_p_out`
  - `full_out`
  - Then read 4 times → `data_out` sequence 0xA0, 0xA1, 0xA2, 0xA3, then `empty_out`=1 and `data_out`=0.
- Overflow: while full, write 0xDEAD → count stays 4. Drained data is 0xA0..0xA3 with no 0xDEAD.
- Underflow: while empty, assert `re_in` for 3 cycles, then write 0x55 → `one_d_out`=1, `data_out`=0x55.
- Simultaneous we/re:
  - At count 0 with `data_in`=0x11 → count 1, `data_out`=0x11.
  - At count 4 → count 3, `full_out`=0, `one_p_out`=1.
  - At count 2 → count stays 2 and FIFO order is preserved.
- Wrap-around: run 10 cycles of concurrent write/read at count 2 with an incrementing pattern → output stream is the exact input stream delayed by 2 entries. Pointers wrap past index 3 at least twice.
